// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
// The ERR state exists only when MEM_TIMEOUT_EN is defined.
package mem_seq_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ST_MDR = 4'd1,
        LD_MAR = 4'd2,
        MEM_RD = 4'd3,
        MEM_WR = 4'd4,
        LD_MDR = 4'd5,
        DONE   = 4'd6
`ifdef MEM_TIMEOUT_EN
        , ERR  = 4'd7
`endif
    } state_t;

    localparam int TIMEOUT_CYCLES_DEF = 16;

    function automatic int wait_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent in a memory wait state.
// The count is 1 in the first wait cycle, so expired means TIMEOUT_CYCLES cycles have elapsed.
module mem_wait_timer
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = wait_cnt_w(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= W'(1);
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt >= W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_access_seq.sv
// MAR/MDR/memory sequencer for a single load or store.
// Define MEM_TIMEOUT_EN to abort a stalled memory wait after TIMEOUT_CYCLES cycles.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic req,
    input  logic we,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic mar_in,
    output logic mdr_in,
    output logic mdr_read,
    output logic mem_read,
    output logic mem_write,
    output logic err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t state, nxt;
    logic   op_we;

`ifdef MEM_TIMEOUT_EN
    logic expired;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .clr_n   (clr_n),
        .clear   (state == LD_MAR),
        .enable  (state == MEM_RD || state == MEM_WR),
        .expired (expired)
    );
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (req) nxt = we ? ST_MDR : LD_MAR;
            ST_MDR: nxt = LD_MAR;
            LD_MAR: nxt = op_we ? MEM_WR : MEM_RD;
            // mem_ready has priority over an expiring timer
            MEM_RD: begin
                if (mem_ready) nxt = LD_MDR;
`ifdef MEM_TIMEOUT_EN
                else if (expired) nxt = ERR;
`endif
            end
            MEM_WR: begin
                if (mem_ready) nxt = DONE;
`ifdef MEM_TIMEOUT_EN
                else if (expired) nxt = ERR;
`endif
            end
            LD_MDR: nxt = DONE;
            DONE:   nxt = IDLE;
`ifdef MEM_TIMEOUT_EN
            ERR:    nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are pure functions of state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mar_in    <= 1'b0;
            mdr_in    <= 1'b0;
            mdr_read  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= nxt;
            if (state == IDLE && req) op_we <= we;
            busy      <= (nxt != IDLE);
`ifdef MEM_TIMEOUT_EN
            done      <= (nxt == DONE) || (nxt == ERR);
            err       <= (nxt == ERR);
`else
            done      <= (nxt == DONE);
`endif
            mar_in    <= (nxt == LD_MAR);
            mdr_in    <= (nxt == ST_MDR) || (nxt == LD_MDR);
            mdr_read  <= (nxt == LD_MDR);
            mem_read  <= (nxt == MEM_RD);
            mem_write <= (nxt == MEM_WR);
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed table, reset/timeout sequences,
// and randomized traffic against a micro-op queue model.
module tb_mem_access_seq;

    localparam int TO = 16;

    // Output vector: {busy,done,err,mar_in,mdr_in,mdr_read,mem_read,mem_write}
    localparam logic [7:0] H_IDLE = 8'h00;
    localparam logic [7:0] H_MDRB = 8'h88;
    localparam logic [7:0] H_MAR  = 8'h90;
    localparam logic [7:0] H_RD   = 8'h82;
    localparam logic [7:0] H_WR   = 8'h81;
    localparam logic [7:0] H_MDRM = 8'h8C;
    localparam logic [7:0] H_DONE = 8'hC0;
    localparam logic [7:0] H_ERR  = 8'hE0;

    logic clk = 1'b0;
    logic clr_n, req, we, mem_ready;
    logic busy, done, mar_in, mdr_in, mdr_read, mem_read, mem_write, err;
    logic [31:0] mdr, bus, mdatain;

    int checks = 0;
    int failures = 0;

    // Micro-op model: 1 mdr<-bus, 2 mar, 3 read wait, 4 write wait, 5 mdr<-mem, 6 done, 7 err
    int q[$];
    int wcnt;

    mem_access_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clr_n(clr_n), .req(req), .we(we), .mem_ready(mem_ready),
        .busy(busy), .done(done), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_read(mdr_read), .mem_read(mem_read), .mem_write(mem_write), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mdr_in) mdr <= mdr_read ? mdatain : bus;

    typedef struct {
        bit r;
        bit w;
        bit rdy;
        logic [7:0] exp;
        bit chk_mdr;
        logic [31:0] mdr_exp;
    } vec_t;

    vec_t tbl[23];

    function automatic logic [7:0] outv();
        return {busy, done, err, mar_in, mdr_in, mdr_read, mem_read, mem_write};
    endfunction

    function automatic logic [7:0] model_out();
        if (q.size() == 0) return H_IDLE;
        case (q[0])
            1: return H_MDRB;
            2: return H_MAR;
            3: return H_RD;
            4: return H_WR;
            5: return H_MDRM;
            6: return H_DONE;
            default: return H_ERR;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit w, input bit rdy);
        if (q.size() == 0) begin
            if (r) begin
                if (w) q = {1, 2, 4, 6};
                else   q = {2, 3, 5, 6};
            end
        end else if (q[0] == 3 || q[0] == 4) begin
            wcnt++;
            if (rdy) void'(q.pop_front());
`ifdef MEM_TIMEOUT_EN
            else if (wcnt >= TO) q = {7};
`endif
        end else begin
            wcnt = 0;
            void'(q.pop_front());
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rdy);
        req = r; we = w; mem_ready = rdy;
        @(posedge clk);
        model_step(r, w, rdy);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input string name);
        #2 clr_n = 1'b0;
        q.delete();
        wcnt = 0;
        #1 chk(name, 32'(outv()), 32'(H_IDLE));
        #1 clr_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 1, H_MAR,  0, 0};
        tbl[1]  = '{0, 1, 1, H_RD,   0, 0};
        tbl[2]  = '{0, 0, 1, H_MDRM, 0, 0};
        tbl[3]  = '{0, 0, 1, H_DONE, 0, 0};
        tbl[4]  = '{0, 0, 1, H_IDLE, 1, 32'hDEADBEEF};
        tbl[5]  = '{1, 1, 0, H_MDRB, 0, 0};
        tbl[6]  = '{0, 0, 0, H_MAR,  0, 0};
        tbl[7]  = '{0, 0, 0, H_WR,   0, 0};
        tbl[8]  = '{0, 0, 0, H_WR,   0, 0};
        tbl[9]  = '{0, 1, 0, H_WR,   0, 0};
        tbl[10] = '{0, 0, 0, H_WR,   0, 0};
        tbl[11] = '{0, 0, 1, H_DONE, 0, 0};
        tbl[12] = '{0, 0, 0, H_IDLE, 1, 32'hA5A5A5A5};
        tbl[13] = '{1, 0, 1, H_MAR,  0, 0};
        tbl[14] = '{1, 1, 1, H_RD,   0, 0};
        tbl[15] = '{1, 1, 1, H_MDRM, 0, 0};
        tbl[16] = '{1, 0, 0, H_DONE, 0, 0};
        tbl[17] = '{1, 0, 0, H_IDLE, 0, 0};
        tbl[18] = '{1, 0, 1, H_MAR,  0, 0};
        tbl[19] = '{0, 0, 1, H_RD,   0, 0};
        tbl[20] = '{0, 0, 1, H_MDRM, 0, 0};
        tbl[21] = '{0, 0, 1, H_DONE, 0, 0};
        tbl[22] = '{0, 0, 0, H_IDLE, 1, 32'hDEADBEEF};

        mdr = '0; bus = 32'hA5A5A5A5; mdatain = 32'hDEADBEEF;
        wcnt = 0;
        clr_n = 1'b0; req = 1'b1; we = 1'b1; mem_ready = 1'b1;
        #1 chk("reset_outputs", 32'(outv()), 32'(H_IDLE));
        repeat (2) @(negedge clk);
        chk("reset_held_clocked", 32'(outv()), 32'(H_IDLE));
        req = 1'b0; we = 1'b0; mem_ready = 1'b0;
        clr_n = 1'b1;
        step(0, 0, 1);
        chk("idle_after_release", 32'(outv()), 32'(H_IDLE));

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].rdy);
            chk($sformatf("tbl_row%0d", i), 32'(outv()), 32'(tbl[i].exp));
            if (tbl[i].chk_mdr) chk($sformatf("tbl_mdr%0d", i), mdr, tbl[i].mdr_exp);
        end

        // Reset abandoned mid-read, then a clean load
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pre_reset_rd", 32'(outv()), 32'(H_RD));
        reset_pulse("reset_mid_rd");
        step(0, 0, 1);
        chk("post_reset_idle", 32'(outv()), 32'(H_IDLE));
        begin
            logic [7:0] seq[4];
            seq = '{H_MAR, H_RD, H_MDRM, H_DONE};
            for (int i = 0; i < 4; i++) begin
                step(i == 0, 0, 1);
                chk($sformatf("post_reset_load%0d", i), 32'(outv()), 32'(seq[i]));
            end
            step(0, 0, 1);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            step(1, 0, 0);
            for (int i = 0; i < 40; i++) begin
                step(0, 0, 0);
                if (outv() == H_RD) n++;
                else break;
            end
            chk("timeout_rd_cycles", n, TO);
            chk("timeout_err", 32'(outv()), 32'(H_ERR));
            step(0, 0, 0);
            chk("timeout_idle", 32'(outv()), 32'(H_IDLE));
            step(1, 0, 0);
            for (int i = 0; i < TO; i++) step(0, 0, 0);
            chk("limit_rd", 32'(outv()), 32'(H_RD));
            step(0, 0, 1);
            chk("limit_ready_wins", 32'(outv()), 32'(H_MDRM));
            step(0, 0, 0);
            chk("limit_done_no_err", 32'(outv()), 32'(H_DONE));
            step(0, 0, 0);
        end
`else
        step(1, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 41; i++) step(0, 0, 0);
        chk("no_timeout_wr_wait", 32'(outv()), 32'(H_WR));
        step(0, 0, 1);
        chk("no_timeout_done", 32'(outv()), 32'(H_DONE));
        step(0, 0, 0);
`endif

        begin
            int stall;
            stall = 0;
            for (int i = 0; i < 600; i++) begin
                bit r, w, rdy;
                if (stall == 0 && $urandom_range(0, 29) == 0) stall = $urandom_range(5, 24);
                r = ($urandom_range(0, 2) == 0);
                w = $urandom_range(0, 1) != 0;
                rdy = (stall == 0) && ($urandom_range(0, 2) != 0);
                if (stall > 0) stall--;
                step(r, w, rdy);
                chk("rand_out", 32'(outv()), 32'(model_out()));
                chk("rand_onehot", ($countones({mar_in, mdr_in, mem_read, mem_write, done}) <= 1), 1);
                if ($urandom_range(0, 79) == 0) reset_pulse("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
